keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad by driving one column low at a time and reading the four row lines. It produces a debounced 4-bit key code with a one-cycle valid strobe and a held-key level. It is the input-side counterpart of the multiplexed 7-segment driver, and its key_o feeds the same datapath that produces digits for display.

---
 rtl/keypad_scanner.sv | 254 +++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad. One column is driven low at a time.
// The four row lines are read back through a two-flop synchroniser. Each full
// scan (columns 0..3) reduces to "was any key down, and which one came first".
// A small FSM debounces that per-scan result into an accepted key code with a
// one-cycle valid strobe and a held-key level.
//
// Parameters
//   SCAN_PERIOD     clock cycles each column stays driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical full scans needed to accept a press
//                   or a release (>= 1)
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous, active-low reset
//   row_i[3:0]     keypad rows, active-low, asynchronous to clk_i
//   col_o[3:0]     keypad columns, active-low, exactly one bit low
//   key_o[3:0]     last accepted key, {row_idx[1:0], col_idx[1:0]}
//   key_valid_o    one-cycle pulse when a new key is accepted
//   key_pressed_o  high while the accepted key is considered held
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_PERIOD    = 27000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_o,
    output logic       key_valid_o,
    output logic       key_pressed_o
);

    localparam int CNT_W = $clog2(SCAN_PERIOD);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [CNT_W-1:0] SCAN_RELOAD = CNT_W'(SCAN_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [DB_W-1:0]  DB_TARGET   = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_ZERO     = '0;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    // Row synchroniser
    logic [3:0] row_meta;
    logic [3:0] row_sync;

    // Column timing
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       col_idx;
    logic             sample;

    // Row decode for the current column
    logic       row_hit;
    logic [1:0] row_idx;

    // Per-scan accumulator and registered scan result
    logic       acc_found;
    logic [3:0] acc_code;
    logic       scan_found;
    logic [3:0] scan_code;
    logic       scan_done;

    // Debounce FSM
    logic [1:0]      state;
    logic [3:0]      cand;
    logic [DB_W-1:0] cnt;
    logic [DB_W-1:0] cnt_next;

    // Two-flop synchroniser. It resets to "no rows low" so that no phantom
    // key appears while the flops refill after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_i;
            row_sync <= row_meta;
        end
    end

    // The sample point is the last cycle of each column. By then the
    // synchronised rows reflect the column that has been driven for at least
    // SCAN_PERIOD-2 cycles.
    assign sample = (scan_cnt == CNT_ZERO);

    // Column down-counter and column rotation. col_o is kept as its own
    // register, not decoded from col_idx, so the pins never glitch.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scan_cnt <= SCAN_RELOAD;
            col_idx  <= 2'd0;
            col_o    <= 4'b1110;
        end else if (sample) begin
            scan_cnt <= SCAN_RELOAD;
            col_idx  <= col_idx + 2'd1;
            col_o    <= {col_o[2:0], col_o[3]};
        end else begin
            scan_cnt <= scan_cnt - 1'b1;
        end
    end

    // Lowest pressed row wins within a column.
    always_comb begin
        row_hit = 1'b1;
        row_idx = 2'd0;
        if (!row_sync[0]) begin
            row_idx = 2'd0;
        end else if (!row_sync[1]) begin
            row_idx = 2'd1;
        end else if (!row_sync[2]) begin
            row_idx = 2'd2;
        end else if (!row_sync[3]) begin
            row_idx = 2'd3;
        end else begin
            row_hit = 1'b0;
        end
    end

    // Per-scan capture. Columns are visited in ascending order, so keeping
    // only the first hit gives column-first, then row, priority. On the
    // column-3 sample the result is published and the accumulator cleared.
    // A hit in column 3 only counts if nothing was found earlier.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc_found  <= 1'b0;
            acc_code   <= 4'd0;
            scan_found <= 1'b0;
            scan_code  <= 4'd0;
        end else if (sample) begin
            if (col_idx == 2'd3) begin
                scan_found <= acc_found | row_hit;
                if (acc_found) begin
                    scan_code <= acc_code;
                end else if (row_hit) begin
                    scan_code <= {row_idx, col_idx};
                end else begin
                    scan_code <= 4'd0;
                end
                acc_found <= 1'b0;
                acc_code  <= 4'd0;
            end else if (!acc_found && row_hit) begin
                acc_found <= 1'b1;
                acc_code  <= {row_idx, col_idx};
            end
        end
    end

    // scan_done is high for exactly the cycle after the column-3 sample,
    // which is when scan_found/scan_code are fresh.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scan_done <= 1'b0;
        end else begin
            scan_done <= sample && (col_idx == 2'd3);
        end
    end

    assign cnt_next = cnt + DB_ONE;

    // Debounce FSM. It only moves on scan_done cycles. Press and release use
    // the same scan count. A single bouncing scan during RELEASE drops back
    // to PRESSED without a new strobe, so a held key reports exactly once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= IDLE;
            cand          <= 4'd0;
            cnt           <= DB_ZERO;
            key_o         <= 4'd0;
            key_valid_o   <= 1'b0;
            key_pressed_o <= 1'b0;
        end else begin
            key_valid_o <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (scan_found) begin
                            cand <= scan_code;
                            if (DB_TARGET == DB_ONE) begin
                                key_o         <= scan_code;
                                key_valid_o   <= 1'b1;
                                key_pressed_o <= 1'b1;
                                cnt           <= DB_ZERO;
                                state         <= PRESSED;
                            end else begin
                                cnt   <= DB_ONE;
                                state <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (!scan_found) begin
                            cnt   <= DB_ZERO;
                            state <= IDLE;
                        end else if (scan_code == cand) begin
                            if (cnt_next == DB_TARGET) begin
                                key_o         <= cand;
                                key_valid_o   <= 1'b1;
                                key_pressed_o <= 1'b1;
                                cnt           <= DB_ZERO;
                                state         <= PRESSED;
                            end else begin
                                cnt <= cnt_next;
                            end
                        end else begin
                            cand <= scan_code;
                            cnt  <= DB_ONE;
                        end
                    end

                    PRESSED: begin
                        if (!scan_found) begin
                            if (DB_TARGET == DB_ONE) begin
                                key_pressed_o <= 1'b0;
                                cnt           <= DB_ZERO;
                                state         <= IDLE;
                            end else begin
                                cnt   <= DB_ONE;
                                state <= RELEASE;
                            end
                        end
                    end

                    RELEASE: begin
                        if (scan_found) begin
                            cnt   <= DB_ZERO;
                            state <= PRESSED;
                        end else if (cnt_next == DB_TARGET) begin
                            key_pressed_o <= 1'b0;
                            cnt           <= DB_ZERO;
                            state         <= IDLE;
                        end else begin
                            cnt <= cnt_next;
                        end
                    end

                    default: begin
                        cnt   <= DB_ZERO;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_PERIOD=4 and DEBOUNCE_SCANS=3,
// so one full scan is 16 cycles. A keypad model pulls a row low whenever a
// held key sits in the column currently driven low.
//
// Reset is released on a falling edge N0, and the bench steps once more to
// N1. After that all stimulus moves in 16-cycle chunks, so every check lands
// on the falling edge just after the FSM has consumed a finished scan. Key
// changes at those points take effect from column 0 of the next scan.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SP        = 4;
    localparam int DS        = 3;
    localparam int SCAN_CYC  = 4 * SP;

    localparam logic [15:0] KEY9    = 16'h0200;
    localparam logic [15:0] KEY3_4  = 16'h0018;
    localparam logic [15:0] NO_KEYS = 16'h0000;

    logic       clk_i;
    logic       rst_i;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] key_o;
    logic       key_valid_o;
    logic       key_pressed_o;

    logic [15:0] keys;
    int          tests_run;
    int          tests_failed;
    int          valid_count;

    keypad_scanner #(
        .SCAN_PERIOD   (SP),
        .DEBOUNCE_SCANS(DS)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .row_i        (row_i),
        .col_o        (col_o),
        .key_o        (key_o),
        .key_valid_o  (key_valid_o),
        .key_pressed_o(key_pressed_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Keypad matrix: key {r,c} held means row r follows column c.
    always_comb begin
        row_i = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_o[c]) begin
                    row_i[r] = 1'b0;
                end
            end
        end
    end

    // Running total of valid pulses; tasks compare against a snapshot.
    initial valid_count = 0;
    always @(posedge clk_i) begin
        if (key_valid_o === 1'b1) begin
            valid_count <= valid_count + 1;
        end
    end

    task automatic run_scans(input logic [15:0] mask, input int n);
        keys = mask;
        repeat (SCAN_CYC * n) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        keys  = NO_KEYS;
        repeat (3) @(negedge clk_i);
        tests_run++;
        if (col_o !== 4'b1110) begin
            tests_failed++;
            $display("[TB] FAIL reset_col: got %b expected 1110", col_o);
        end
        tests_run++;
        if (key_o !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_key: got %h expected 0", key_o);
        end
        tests_run++;
        if (key_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", key_valid_o);
        end
        tests_run++;
        if (key_pressed_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pressed: got %b expected 0", key_pressed_o);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        tests_run++;
        if (col_o !== 4'b1110) begin
            tests_failed++;
            $display("[TB] FAIL release_col: got %b expected 1110", col_o);
        end
    endtask

    task automatic test_column_rotation;
        logic [3:0] exp_col [4];
        int base;
        exp_col[0] = 4'b1101;
        exp_col[1] = 4'b1011;
        exp_col[2] = 4'b0111;
        exp_col[3] = 4'b1110;
        base = valid_count;
        for (int i = 0; i < 4; i++) begin
            repeat (SP) @(negedge clk_i);
            tests_run++;
            if (col_o !== exp_col[i]) begin
                tests_failed++;
                $display("[TB] FAIL col_step%0d: got %b expected %b", i, col_o, exp_col[i]);
            end
        end
        run_scans(NO_KEYS, 9);
        tests_run++;
        if (valid_count != base) begin
            tests_failed++;
            $display("[TB] FAIL idle_valid: got %0d pulses expected 0", valid_count - base);
        end
        tests_run++;
        if (key_pressed_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_pressed: got %b expected 0", key_pressed_o);
        end
    endtask

    task automatic test_press_accept;
        int base;
        base = valid_count;
        run_scans(KEY9, 2);
        tests_run++;
        if (key_pressed_o !== 1'b0 || valid_count != base) begin
            tests_failed++;
            $display("[TB] FAIL early_accept: pressed %b pulses %0d expected 0 and 0", key_pressed_o, valid_count - base);
        end
        run_scans(KEY9, 1);
        tests_run++;
        if (key_o !== 4'h9) begin
            tests_failed++;
            $display("[TB] FAIL accept_key: got %h expected 9", key_o);
        end
        tests_run++;
        if (key_valid_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL accept_valid: got %b expected 1", key_valid_o);
        end
        tests_run++;
        if (key_pressed_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL accept_pressed: got %b expected 1", key_pressed_o);
        end
        run_scans(KEY9, 10);
        tests_run++;
        if (valid_count - base != 1) begin
            tests_failed++;
            $display("[TB] FAIL held_pulses: got %0d expected 1", valid_count - base);
        end
        tests_run++;
        if (key_pressed_o !== 1'b1 || key_o !== 4'h9) begin
            tests_failed++;
            $display("[TB] FAIL held_state: pressed %b key %h expected 1 and 9", key_pressed_o, key_o);
        end
    endtask

    task automatic test_release;
        int base;
        base = valid_count;
        run_scans(NO_KEYS, 2);
        tests_run++;
        if (key_pressed_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL release_absent2: got %b expected 1", key_pressed_o);
        end
        run_scans(KEY9, 1);
        tests_run++;
        if (key_pressed_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL release_bounce: got %b expected 1", key_pressed_o);
        end
        run_scans(NO_KEYS, 2);
        tests_run++;
        if (key_pressed_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL release_restart: got %b expected 1", key_pressed_o);
        end
        run_scans(NO_KEYS, 1);
        tests_run++;
        if (key_pressed_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL release_done: got %b expected 0", key_pressed_o);
        end
        tests_run++;
        if (key_o !== 4'h9 || valid_count != base) begin
            tests_failed++;
            $display("[TB] FAIL release_hold: key %h pulses %0d expected 9 and 0", key_o, valid_count - base);
        end
    endtask

    task automatic test_bounce;
        int base;
        base = valid_count;
        run_scans(KEY9, 2);
        run_scans(NO_KEYS, 1);
        run_scans(KEY9, 2);
        tests_run++;
        if (valid_count != base || key_pressed_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bounce_early: pulses %0d pressed %b expected 0 and 0", valid_count - base, key_pressed_o);
        end
        run_scans(KEY9, 1);
        tests_run++;
        if (key_valid_o !== 1'b1 || key_o !== 4'h9) begin
            tests_failed++;
            $display("[TB] FAIL bounce_accept: valid %b key %h expected 1 and 9", key_valid_o, key_o);
        end
        run_scans(KEY9, 1);
        tests_run++;
        if (valid_count - base != 1) begin
            tests_failed++;
            $display("[TB] FAIL bounce_pulses: got %0d expected 1", valid_count - base);
        end
    endtask

    task automatic test_simultaneous;
        int base;
        run_scans(NO_KEYS, 3);
        tests_run++;
        if (key_pressed_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL simul_idle: got %b expected 0", key_pressed_o);
        end
        base = valid_count;
        run_scans(KEY3_4, 3);
        tests_run++;
        if (key_o !== 4'h4 || key_valid_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL simul_key: key %h valid %b expected 4 and 1", key_o, key_valid_o);
        end
        run_scans(KEY3_4, 1);
        tests_run++;
        if (valid_count - base != 1 || key_pressed_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL simul_pulses: pulses %0d pressed %b expected 1 and 1", valid_count - base, key_pressed_o);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        keys = KEY3_4;
        repeat (6) @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (col_o !== 4'b1110) begin
            tests_failed++;
            $display("[TB] FAIL midreset_col: got %b expected 1110", col_o);
        end
        tests_run++;
        if (key_o !== 4'h0 || key_pressed_o !== 1'b0 || key_valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_out: key %h pressed %b valid %b expected 0 0 0", key_o, key_pressed_o, key_valid_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        base = valid_count;
        @(negedge clk_i);
        run_scans(KEY3_4, 2);
        tests_run++;
        if (valid_count != base || key_pressed_o !== 1'b0 || key_o !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_early: pulses %0d pressed %b key %h expected 0 0 0", valid_count - base, key_pressed_o, key_o);
        end
        run_scans(KEY3_4, 1);
        tests_run++;
        if (key_o !== 4'h4 || key_valid_o !== 1'b1 || key_pressed_o !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_accept: key %h valid %b pressed %b expected 4 1 1", key_o, key_valid_o, key_pressed_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        keys         = NO_KEYS;
        rst_i        = 1'b0;
        test_reset;
        test_column_rotation;
        test_press_accept;
        test_release;
        test_bounce;
        test_simultaneous;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
